// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end.
//   - Scan-code constants used by the decoder.
//   - Frame receiver state encoding.
//   - Default inactivity timeout (1 ms at 50 MHz).
//   - Odd-parity helper used by the receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_NONE  = 8'h00;

  localparam int unsigned PS2_TIMEOUT_DEFAULT = 50000;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  // A PS/2 frame is good when data byte plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver.
// Synchronises the raw PS/2 lines, detects falling edges of the PS/2 clock,
// shifts in start/8 data (LSB first)/parity/stop, and checks odd parity and
// the stop bit. A partial frame that stalls for TIMEOUT_CYCLES is aborted.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   ps2_clk_i    raw PS/2 clock (asynchronous)
//   ps2_data_i   raw PS/2 data (asynchronous)
//   rx_byte_o    last received data byte, valid while rx_strobe_o is high
//   rx_strobe_o  one-cycle pulse: good frame received
//   rx_err_o     one-cycle pulse: parity error, bad stop bit or timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_strobe_o,
  output logic       rx_err_o
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   prev_clk_q;

  rx_state_e   state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_err_q, par_err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        strobe_q, strobe_d;
  logic        err_q, err_d;

  logic cur_clk;
  logic data_s;
  logic fall;

  assign cur_clk = clk_sync_q[SYNC_STAGES-1];
  assign data_s  = data_sync_q[SYNC_STAGES-1];
  assign fall    = prev_clk_q & ~cur_clk;

  // Synchroniser and edge-detect history. Lines idle high, so reset to 1
  // to avoid a phantom falling edge right after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      prev_clk_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      prev_clk_q  <= cur_clk;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      par_err_q <= 1'b0;
      tmo_q     <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      par_err_q <= par_err_d;
      tmo_q     <= tmo_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  // Data shift register carries no control meaning, so it is left unreset.
  always_ff @(posedge clk_i) begin
    shreg_q <= shreg_d;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_err_d = par_err_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;

    // Inactivity counter: cleared by every fall, saturates at TMO_MAX.
    if (fall) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = tmo_q;
    end

    if ((state_q != RX_IDLE) && !fall && (tmo_q == TMO_MAX)) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        RX_IDLE: begin
          // A high bit here is not a start bit; it is silently ignored.
          if (!data_s) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
            par_err_d = 1'b0;
          end
        end
        RX_DATA: begin
          shreg_d   = {data_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = RX_PARITY;
          end
        end
        RX_PARITY: begin
          par_err_d = ~odd_parity_ok(shreg_q, data_s);
          state_d   = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (data_s && !par_err_q) begin
            strobe_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign rx_byte_o   = shreg_q;
  assign rx_strobe_o = strobe_q;
  assign rx_err_o    = err_q;

endmodule

// File: rtl/ps2_key_input.sv
// PS/2 keyboard front end producing the user_input byte for the column logic.
// Decodes make / break (F0) / extended (E0) prefixes from received frames,
// holds the current make code and pulses key_valid once per new keypress.
// A consumer acknowledge clears the held code while remembering it, so
// typematic repeats of that key stay suppressed until its break arrives.
// Ports:
//   clock         system clock (50 MHz)
//   reset_signal  synchronous reset, active-high
//   ps2_clk       raw PS/2 clock (asynchronous)
//   ps2_data      raw PS/2 data (asynchronous)
//   key_ack       consumer took user_input; clear it
//   user_input    current make code, 8'h00 = no key
//   key_valid     one-cycle pulse: new make code loaded into user_input
//   key_held      high while the last make is neither released nor acked
//   frame_error   one-cycle pulse: parity error, bad stop bit or timeout
module ps2_key_input
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset_signal,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_ack,
  output logic [7:0] user_input,
  output logic       key_valid,
  output logic       key_held,
  output logic       frame_error
);

  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       rx_err;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk_i       (clock),
    .rst_i       (reset_signal),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .rx_byte_o   (rx_byte),
    .rx_strobe_o (rx_strobe),
    .rx_err_o    (rx_err)
  );

  logic [7:0] byte_q;
  logic       strb_q;
  logic       break_q, break_d;
  logic       ext_q, ext_d;
  logic [7:0] last_make_q, last_make_d;
  logic [7:0] user_q, user_d;
  logic       held_q, held_d;
  logic       valid_q, valid_d;
  logic       ferr_q;

  // Capture stage: decode acts on the byte one cycle after the receiver strobe.
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      strb_q <= 1'b0;
    end else begin
      strb_q <= rx_strobe;
    end
  end

  always_ff @(posedge clock) begin
    byte_q <= rx_byte;
  end

  // Output stage
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      break_q     <= 1'b0;
      ext_q       <= 1'b0;
      last_make_q <= PS2_NONE;
      user_q      <= PS2_NONE;
      held_q      <= 1'b0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      break_q     <= break_d;
      ext_q       <= ext_d;
      last_make_q <= last_make_d;
      user_q      <= user_d;
      held_q      <= held_d;
      valid_q     <= valid_d;
      ferr_q      <= rx_err;
    end
  end

  always_comb begin
    break_d     = break_q;
    ext_d       = ext_q;
    last_make_d = last_make_q;
    user_d      = user_q;
    held_d      = held_q;
    valid_d     = 1'b0;

    // Ack is applied first so that a make decoded in the same cycle overrides it.
    if (key_ack) begin
      user_d = PS2_NONE;
      held_d = 1'b0;
    end

    if (strb_q) begin
      if (byte_q == PS2_BREAK) begin
        break_d = 1'b1;
      end else if (byte_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        // Extended keys are not supported: drop the code and any pending break.
        ext_d   = 1'b0;
        break_d = 1'b0;
      end else if (break_q) begin
        break_d = 1'b0;
        if (byte_q == last_make_q) begin
          last_make_d = PS2_NONE;
          user_d      = PS2_NONE;
          held_d      = 1'b0;
        end
      end else if (byte_q != last_make_q) begin
        last_make_d = byte_q;
        user_d      = byte_q;
        held_d      = 1'b1;
        valid_d     = 1'b1;
      end
    end
  end

  assign user_input  = user_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;
  assign frame_error = ferr_q;

endmodule
